// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU, with load-use hazard detection.
// Define ID_EX_FWD_EN to build the MEM/WB forwarding muxes; otherwise RAW hazards stall instead.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              hold,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);

  localparam int unsigned OP_W = 5;
  localparam logic [OP_W-1:0] OP_BUBBLE = OP_W'(1);

  logic              valid_q, valid_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic              use_imm_q, use_imm_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;

  logic              uses_rt, ex_dep, hazard, load_bubble;
  logic [DATA_W-1:0] fwd_a, fwd_rt;

  // Hazard detection: a source of the ID instruction depends on a result not yet usable.
  always_comb begin
    uses_rt = !id_use_imm || id_mem_write;
    ex_dep  = id_valid && (rd_q != '0) &&
              ((id_rs == rd_q) || (uses_rt && (id_rt == rd_q)));
    hazard  = valid_q && mem_read_q && ex_dep;
`ifndef ID_EX_FWD_EN
    hazard  = hazard || (valid_q && reg_write_q && ex_dep) ||
              (id_valid && mem_reg_write && (mem_rd != '0) &&
               ((id_rs == mem_rd) || (uses_rt && (id_rt == mem_rd))));
`endif
    stall   = hazard && !hold && !flush;
  end

  // Next state: bubble on flush/stall/bad opcode, keep on hold, else capture.
  always_comb begin
    valid_d     = valid_q;
    op_d        = op_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    load_bubble = flush || stall || (!hold && !$onehot(id_alu_op));
    if (load_bubble) begin
      valid_d     = 1'b0;
      op_d        = OP_BUBBLE;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      use_imm_d   = 1'b0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!hold) begin
      valid_d     = id_valid;
      op_d        = id_valid ? id_alu_op : OP_BUBBLE;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      use_imm_d   = id_use_imm;
      rs_d        = id_rs;
      rt_d        = id_rt;
      rd_d        = id_rd;
      reg_write_d = id_valid && id_reg_write;
      mem_read_d  = id_valid && id_mem_read;
      mem_write_d = id_valid && id_mem_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      op_q        <= OP_BUBBLE;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      op_q        <= op_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

`ifdef ID_EX_FWD_EN
  // MEM result beats WB result; register 0 never matches.
  always_comb begin
    fwd_a = rs_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs_q))     fwd_a = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_q))   fwd_a = wb_result;
    fwd_rt = rt_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rt_q))     fwd_rt = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_q))   fwd_rt = wb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_result, wb_result, wb_reg_write, wb_rd, rs_q, rt_q};
  assign fwd_a  = rs_data_q;
  assign fwd_rt = rt_data_q;
`endif

  assign alu_a         = fwd_a;
  assign alu_b         = use_imm_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = valid_q;
  assign alu_op        = op_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow ID_EX_FWD_EN when it is defined.
module tb_id_ex_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam logic [4:0] OP_ADD = 5'b00001, OP_SUB = 5'b00010, OP_AND = 5'b00100,
                         OP_OR = 5'b10000;

  logic clk, rst;
  logic id_valid, id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0] id_alu_op;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic flush, hold, mem_reg_write, wb_reg_write;
  logic [REG_AW-1:0] mem_rd, wb_rd;
  logic [DATA_W-1:0] mem_result, wb_result;
  logic stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0] alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, ex_store_data;
  logic [REG_AW-1:0] ex_rd;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .hold(hold), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_result(mem_result), .wb_result(wb_result),
    .stall(stall), .ex_valid(ex_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  op;
    logic [31:0] a, b, st;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_run = 0;
  int n_fail = 0;

  function automatic exp_t obs();
    exp_t o;
    o.v = ex_valid; o.op = alu_op; o.a = alu_a; o.b = alu_b; o.st = ex_store_data;
    o.rd = ex_rd; o.rw = ex_reg_write; o.mr = ex_mem_read; o.mw = ex_mem_write;
    return o;
  endfunction

  function automatic exp_t mk(input logic v, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] st, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw);
    exp_t x;
    x.v = v; x.op = op; x.a = a; x.b = b; x.st = st; x.rd = rd; x.rw = rw; x.mr = mr; x.mw = mw;
    return x;
  endfunction

  function automatic exp_t bubble();
    return mk(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_alu_op = 5'd0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_use_imm = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    flush = 1'b0; hold = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    mem_rd = '0; wb_rd = '0; mem_result = '0; wb_result = '0;
  endtask

  task automatic instr(input logic v, input logic [4:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] imm, input logic ui,
                       input logic rw, input logic mr, input logic mw);
    id_valid = v; id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_use_imm = ui;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
    instr(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, OP_ADD, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0));
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_first_capture: got %h want %h", obs(), e); end
    #2 rst = 1'b1;
    sb.push_back(bubble());
    #1;
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_async: got %h want %h", obs(), e); end
    n_run++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    idle(); tick(); rst = 1'b0;
  endtask

  task automatic test_fwd_priority();
    idle();
    instr(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    mem_reg_write = 1'b1; mem_rd = 5'd1; mem_result = 32'd100;
    wb_reg_write = 1'b1; wb_rd = 5'd2; wb_result = 32'd200;
`ifdef ID_EX_FWD_EN
    sb.push_back(mk(1'b1, OP_ADD, 32'd100, 32'd200, 32'd200, 5'd3, 1'b1, 1'b0, 1'b0));
`else
    sb.push_back(mk(1'b1, OP_ADD, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0));
`endif
    #1;
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL fwd_mem_wb: got %h want %h", obs(), e); end
    wb_rd = 5'd1; wb_result = 32'd300;
`ifdef ID_EX_FWD_EN
    sb.push_back(mk(1'b1, OP_ADD, 32'd100, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0));
`else
    sb.push_back(mk(1'b1, OP_ADD, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0));
`endif
    #1;
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL fwd_mem_wins: got %h want %h", obs(), e); end
    idle();
    instr(1'b1, OP_AND, 5'd7, 5'd8, 5'd9, 32'd11, 32'd22, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, OP_AND, 32'd11, 32'hFFFF_FFFC, 32'd22, 5'd9, 1'b1, 1'b0, 1'b0));
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL imm_operand: got %h want %h", obs(), e); end
    idle();
    wb_reg_write = 1'b1; wb_rd = 5'd8; wb_result = 32'd55;
`ifdef ID_EX_FWD_EN
    sb.push_back(mk(1'b1, OP_AND, 32'd11, 32'hFFFF_FFFC, 32'd55, 5'd9, 1'b1, 1'b0, 1'b0));
`else
    sb.push_back(mk(1'b1, OP_AND, 32'd11, 32'hFFFF_FFFC, 32'd22, 5'd9, 1'b1, 1'b0, 1'b0));
`endif
    #1;
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL store_fwd_wb: got %h want %h", obs(), e); end
  endtask

  task automatic test_load_use();
    idle();
    instr(1'b1, OP_ADD, 5'd1, 5'd0, 5'd4, 32'd1000, 32'd0, 32'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back(mk(1'b1, OP_ADD, 32'd1000, 32'd8, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL load_capture: got %h want %h", obs(), e); end
    instr(1'b1, OP_SUB, 5'd4, 5'd6, 5'd5, 32'hDEAD, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; n_run++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b want 1", stall); end
    sb.push_back(bubble());
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL load_use_bubble: got %h want %h", obs(), e); end
    mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result = 32'd77;
    #1;
`ifdef ID_EX_FWD_EN
    n_run++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b want 0", stall); end
`else
    n_run++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL mem_raw_stall: got %b want 1", stall); end
    sb.push_back(bubble());
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL mem_raw_bubble: got %h want %h", obs(), e); end
    mem_reg_write = 1'b0; id_rs_data = 32'd77;
    #1; n_run++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b want 0", stall); end
`endif
    sb.push_back(mk(1'b1, OP_SUB, 32'd77, 32'd9, 32'd9, 5'd5, 1'b1, 1'b0, 1'b0));
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL load_use_dependent: got %h want %h", obs(), e); end
  endtask

  task automatic test_reg0();
    idle();
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'd123;
    instr(1'b1, OP_ADD, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, OP_ADD, 32'd0, 32'd5, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0));
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL reg0_no_fwd: got %h want %h", obs(), e); end
    instr(1'b1, OP_ADD, 5'd2, 5'd0, 5'd0, 32'd40, 32'd0, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back(mk(1'b1, OP_ADD, 32'd40, 32'd4, 32'd0, 5'd0, 1'b1, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL reg0_load: got %h want %h", obs(), e); end
    instr(1'b1, OP_OR, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; n_run++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reg0_stall: got %b want 0", stall); end
    sb.push_back(mk(1'b1, OP_OR, 32'd0, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0));
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL reg0_dependent: got %h want %h", obs(), e); end
  endtask

  task automatic test_flush_hold();
    exp_t held;
    idle();
    instr(1'b1, OP_ADD, 5'd1, 5'd0, 5'd4, 32'd1000, 32'd0, 32'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    instr(1'b1, OP_SUB, 5'd4, 5'd6, 5'd5, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1; n_run++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_masks_stall: got %b want 0", stall); end
    sb.push_back(bubble());
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL flush_bubble: got %h want %h", obs(), e); end
    flush = 1'b0;
    instr(1'b1, OP_OR, 5'd1, 5'd2, 5'd7, 32'd3, 32'd12, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    held = mk(1'b1, OP_OR, 32'd3, 32'd12, 32'd12, 5'd7, 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    instr(1'b1, OP_SUB, 5'd7, 5'd7, 5'd8, 32'd99, 32'd98, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1; n_run++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL hold_masks_stall: got %b want 0", stall); end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(held);
      tick();
      e = sb.pop_front(); n_run++;
      if (obs() !== e) begin n_fail++; $display("FAIL hold_cycle%0d: got %h want %h", i, obs(), e); end
    end
    hold = 1'b0;
  endtask

  task automatic test_invalid_op();
    idle();
    instr(1'b1, 5'b00011, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    sb.push_back(bubble());
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL invalid_op: got %h want %h", obs(), e); end
    instr(1'b0, OP_SUB, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    sb.push_back(mk(1'b0, OP_ADD, 32'd5, 32'd6, 32'd6, 5'd3, 1'b0, 1'b0, 1'b0));
    tick();
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL invalid_slot: got %h want %h", obs(), e); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rs, rt, rd, op;
    logic [31:0] rsd, rtd, imm;
    logic        ui;
    idle();
    for (int i = 0; i < 8; i++) begin
      rs  = 5'($urandom_range(1, 15));
      rt  = 5'($urandom_range(1, 15));
      rd  = 5'($urandom_range(16, 31));
      op  = 5'(5'd1 << $urandom_range(0, 4));
      rsd = $urandom; rtd = $urandom; imm = $urandom;
      ui  = 1'($urandom_range(0, 1));
      instr(1'b1, op, rs, rt, rd, rsd, rtd, imm, ui, 1'b1, 1'b0, 1'b0);
      sb.push_back(mk(1'b1, op, rsd, ui ? imm : rtd, rtd, rd, 1'b1, 1'b0, 1'b0));
      tick();
      e = sb.pop_front(); n_run++;
      if (obs() !== e) begin n_fail++; $display("FAIL back_to_back%0d: got %h want %h", i, obs(), e); end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_reg0();
    test_flush_hold();
    test_invalid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that captures decoded instructions and drives the EX-stage ALU. Latches the operands and the one-hot 5-bit ALU opcode. Applies MEM/WB operand forwarding to the ALU inputs and detects load-use hazards. Sits between the decode stage/register file and the ALU, and guarantees the ALU only ever sees a valid one-hot opcode.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, register-address width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_alu_op  in  5  one-hot: 00001 add, 00010 sub, 00100 and, 01000 slt, 10000 or
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_use_imm  in  1  B operand = immediate instead of rt
- id_rs, id_rt, id_rd  in  REG_AW  source and destination register numbers
- id_reg_write, id_mem_read, id_mem_write  in  1  decoded control bits
- flush  in  1  kill the instruction entering EX (branch taken)
- hold  in  1  downstream busy; freeze the stage
- mem_reg_write, wb_reg_write  in  1  MEM/WB stages will write a register
- mem_rd, wb_rd  in  REG_AW  MEM/WB destination registers
- mem_result, wb_result  in  DATA_W  MEM/WB write-back values
- stall  out  1  load-use hazard; upstream must hold IF/ID
- ex_valid  out  1  EX slot holds a real instruction
- alu_op  out  5  registered opcode (always one-hot)
- alu_a, alu_b  out  DATA_W  forwarded ALU operands
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_rd  out  REG_AW; ex_reg_write, ex_mem_read, ex_mem_write  out  1

## Operation
- Priority at each rising edge: rst > flush > hold > stall > load.
- **Reset** (async, immediate): ex_valid=0, alu_op=00001, all data, register numbers and control outputs = 0.
- **Flush** loads a bubble:
  - ex_valid=0, alu_op=00001, ex_reg_write/mem_read/mem_write=0.
  - Data fields are don't-care; the bench checks them as 0.
- **Hold** keeps every register unchanged, including a bubble.
- **Stall** loads a bubble (same as flush). Upstream keeps the ID instruction, which re-presents next cycle.
- **Load** captures all id_* fields, with ex_valid=id_valid.
  - If id_valid=0, control bits are forced to 0 and alu_op to 00001.
  - If id_alu_op is not one-hot, a bubble is loaded instead.
- **Stall equation:** stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs==ex_rd | (id_rt==ex_rd & (!id_use_imm | id_mem_write))).
- stall is masked to 0 while hold=1 or flush=1.
- **Forwarding** is combinational on registered rs/rt, applied independently to A and to rt:
  - MEM match (mem_reg_write, mem_rd!=0, mem_rd==reg) takes priority over WB match.
  - No match: use the registered register-file data.
  - Register 0 is never forwarded.
- **B operand:** alu_b = use_imm ? imm : forwarded rt. ex_store_data = forwarded rt always.

## Timing
- Capture-to-ALU latency: 1 cycle. alu_a/alu_b are valid combinationally within the cycle after capture.
- Forwarded paths follow mem_*/wb_* inputs combinationally, with no extra latency.
- stall is combinational from id_* and registered EX state; it is asserted in the same cycle the hazard is visible.
- A load followed by a dependent instruction gives exactly one bubble cycle; the dependent value then arrives via MEM forwarding.
- rst asserted mid-hold or mid-stall clears immediately. The first capture happens on the first rising edge after rst deasserts.
- flush and stall together: bubble, stall=0.

## Configuration
- ID_EX_FWD_EN defined: forwarding muxes present as described.
- ID_EX_FWD_EN undefined:
  - Forwarding is removed: alu_a = registered rs data, rt path = registered rt data.
  - stall also asserts for any RAW dependence on EX (ex_reg_write, ex_valid) or MEM (mem_reg_write) with rd!=0, using the same rs/rt usage rules.
  - The mem_result/wb_result ports remain but are unused.

## Test plan
- **Reset:** assert rst mid-stream, no clock. Required: ex_valid=0, alu_op=00001, alu_a=alu_b=0 immediately.
- **Forwarding priority:** capture add r3=r1+r2 with rs_data=5, rt_data=7, mem_rd=1 (mem_result=100), wb_rd=2 (wb_result=200). Required: alu_a=100, alu_b=200. Then set wb_rd=1, wb_result=300 as well. Required: alu_a stays 100 (MEM wins).
- **Load-use:** lw r4 followed by sub r5=r4-r6. Required: stall=1 for one cycle and one bubble (ex_valid=0). The sub then captures with alu_a=mem_result.
- **Register 0:** mem_rd=0, mem_reg_write=1, id_rs=0, rs_data=0. Required: alu_a=0. Also lw r0 followed by a dependent instruction gives stall=0.
- **Flush vs stall, hold:** flush+stall in the same cycle. Required: bubble, stall=0. Then hold=1 for 3 cycles with a valid instruction in EX. Required: outputs are identical on all 3 cycles.
- **Invalid opcode:** id_alu_op=00011, id_valid=1. Required: ex_valid=0, alu_op=00001, ex_reg_write=0.
